// File: rtl/tff_mode_counter.sv
// rtl/tff_mode_counter.sv - WIDTH-bit JK/T register bank and up/down modulo counter
// Optional define TFF_CNT_SAT_EN makes the count modes saturate instead of wrapping.
module tff_mode_counter #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_T    = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_DOWN = 2'b11;

  logic [WIDTH-1:0] up_tog;
  logic [WIDTH-1:0] dn_tog;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             carry_up;
  logic             carry_dn;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (q >= MAX_Q);
  assign at_zero = (q == '0);

  // Toggle masks for the counter: a cell flips when every lower cell is 1 (up) or 0 (down).
  always_comb begin
    up_tog   = '0;
    dn_tog   = '0;
    carry_up = 1'b1;
    carry_dn = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_tog[i] = carry_up;
      dn_tog[i] = carry_dn;
      carry_up  = carry_up & q[i];
      carry_dn  = carry_dn & ~q[i];
    end
  end

  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (load) begin
      q_next = d;
    end else if (en) begin
      case (mode)
        MODE_JK:   q_next = (j & ~q) | (~k & q);
        MODE_T:    q_next = q ^ t;
        MODE_UP: begin
          if (at_max) begin
`ifdef TFF_CNT_SAT_EN
            q_next    = MAX_Q;
`else
            q_next    = '0;
            wrap_next = 1'b1;
`endif
          end else begin
            q_next = q ^ up_tog;
          end
        end
        MODE_DOWN: begin
          if (at_zero) begin
`ifdef TFF_CNT_SAT_EN
            q_next    = '0;
`else
            q_next    = MAX_Q;
            wrap_next = 1'b1;
`endif
          end else begin
            q_next = q ^ dn_tog;
          end
        end
        default:   q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
    end
  end

  assign qbar = ~q;
  assign tc   = ((mode == MODE_UP) && at_max) || ((mode == MODE_DOWN) && at_zero);

endmodule

// File: tb/tb_tff_mode_counter.sv
// tb/tb_tff_mode_counter.sv - self-checking bench for tff_mode_counter (WIDTH=4, MAX_VAL=9)
module tb_tff_mode_counter;

  localparam int W   = 4;
  localparam int MAX = 9;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         load;
  logic [1:0]   mode;
  logic [W-1:0] d, j, k, t;
  logic [W-1:0] q, qbar;
  logic         tc, wrap;

  int total = 0;
  int bad   = 0;

  int mq;
  int mw;

  typedef struct {
    logic       ld;
    logic       en;
    logic [1:0] md;
    logic [3:0] d;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] t;
    int         eq;
    int         etc;
    int         ew;
  } vec_t;

  vec_t vecs[$];

  tff_mode_counter #(.WIDTH(W), .MAX_VAL(MAX)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .mode(mode),
    .d(d), .j(j), .k(k), .t(t),
    .q(q), .qbar(qbar), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference behaviour stated directly as integer arithmetic on the count value.
  task automatic model_edge();
    int nq;
    nq = mq;
    mw = 0;
    if (load) begin
      nq = int'(d);
    end else if (en) begin
      case (mode)
        2'd0: begin
          for (int b = 0; b < W; b++) begin
            case ({j[b], k[b]})
              2'b01: nq = nq & ~(1 << b);
              2'b10: nq = nq | (1 << b);
              2'b11: nq = nq ^ (1 << b);
              default: ;
            endcase
          end
        end
        2'd1: nq = mq ^ int'(t);
        2'd2: begin
          if (mq >= MAX) begin
`ifdef TFF_CNT_SAT_EN
            nq = MAX;
`else
            nq = 0; mw = 1;
`endif
          end else nq = mq + 1;
        end
        default: begin
          if (mq == 0) begin
`ifdef TFF_CNT_SAT_EN
            nq = 0;
`else
            nq = MAX; mw = 1;
`endif
          end else nq = mq - 1;
        end
      endcase
    end
    mq = nq % 16;
  endtask

  function automatic int model_tc();
    return ((mode == 2'd2 && mq >= MAX) || (mode == 2'd3 && mq == 0)) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input vec_t v);
    load = v.ld; en = v.en; mode = v.md; d = v.d; j = v.j; k = v.k; t = v.t;
  endtask

  task automatic add(input logic ld, input logic e, input logic [1:0] md, input logic [3:0] dv,
                     input logic [3:0] jv, input logic [3:0] kv, input logic [3:0] tv,
                     input int eq, input int etc, input int ew);
    vec_t v;
    v.ld = ld; v.en = e; v.md = md; v.d = dv; v.j = jv; v.k = kv; v.t = tv;
    v.eq = eq; v.etc = etc; v.ew = ew;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; load = 1'b0; mode = 2'd0;
    d = '0; j = '0; k = '0; t = '0;
    mq = 0; mw = 0;

    // Up count from reset, through the 9 -> 0 wrap.
    for (int i = 1; i <= 9; i++) add(0, 1, 2'd2, 0, 0, 0, 0, i, (i == 9) ? 1 : 0, 0);
`ifdef TFF_CNT_SAT_EN
    add(0, 1, 2'd2, 0, 0, 0, 0, 9, 1, 0);
    add(0, 1, 2'd2, 0, 0, 0, 0, 9, 1, 0);
`else
    add(0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 2'd2, 0, 0, 0, 0, 1, 0, 0);
`endif
    // Down count after loading 2.
    add(1, 0, 2'd3, 2, 0, 0, 0, 2, 0, 0);
    add(0, 1, 2'd3, 0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 2'd3, 0, 0, 0, 0, 0, 1, 0);
`ifdef TFF_CNT_SAT_EN
    add(0, 1, 2'd3, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 2'd3, 0, 0, 0, 0, 0, 1, 0);
`else
    add(0, 1, 2'd3, 0, 0, 0, 0, 9, 0, 1);
    add(0, 1, 2'd3, 0, 0, 0, 0, 8, 0, 0);
`endif
    // JK bank.
    add(1, 0, 2'd0, 4'b1010, 0, 0, 0, 4'b1010, 0, 0);
    add(0, 1, 2'd0, 0, 4'b0011, 4'b0101, 0, 4'b1011, 0, 0);
    // T bank, enable gating, load overriding en.
    add(1, 0, 2'd1, 4'b0110, 0, 0, 0, 4'b0110, 0, 0);
    add(0, 0, 2'd1, 0, 0, 0, 4'b1100, 4'b0110, 0, 0);
    add(0, 1, 2'd1, 0, 0, 0, 4'b1100, 4'b1010, 0, 0);
    add(1, 0, 2'd1, 4'b0011, 0, 0, 4'b1100, 4'b0011, 0, 0);
    // Out-of-range loads.
    add(1, 0, 2'd2, 4'hC, 0, 0, 0, 12, 1, 0);
`ifdef TFF_CNT_SAT_EN
    add(0, 1, 2'd2, 0, 0, 0, 0, 9, 1, 0);
`else
    add(0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 1);
`endif
    add(1, 0, 2'd3, 4'hC, 0, 0, 0, 12, 0, 0);
    add(0, 1, 2'd3, 0, 0, 0, 0, 11, 0, 0);
    // Held load reloads every edge and keeps wrap low.
    add(1, 1, 2'd2, 5, 0, 0, 0, 5, 0, 0);
    add(1, 1, 2'd2, 5, 0, 0, 0, 5, 0, 0);
    add(0, 1, 2'd2, 0, 0, 0, 0, 6, 0, 0);

    #2;
    check("reset_q", int'(q), 0);
    check("reset_qbar", int'(qbar), 15);
    check("reset_wrap", int'(wrap), 0);
    check("reset_tc_jk", int'(tc), 0);
    mode = 2'd3; #1;
    check("reset_tc_down", int'(tc), 1);
    mode = 2'd0;
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      tick();
      check($sformatf("vec%0d_q", i), int'(q), vecs[i].eq);
      check($sformatf("vec%0d_qbar", i), int'(qbar), (~vecs[i].eq) & 15);
      check($sformatf("vec%0d_tc", i), int'(tc), vecs[i].etc);
      check($sformatf("vec%0d_wrap", i), int'(wrap), vecs[i].ew);
    end

    // Asynchronous reset between edges at q=7.
    load = 1'b1; en = 1'b0; mode = 2'd2; d = 4'd7;
    tick();
    check("pre_reset_q", int'(q), 7);
    load = 1'b0; en = 1'b1;
    #2 reset = 1'b0;
    #1;
    mq = 0; mw = 0;
    check("midreset_q", int'(q), 0);
    check("midreset_qbar", int'(qbar), 15);
    check("midreset_wrap", int'(wrap), 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("post_reset_q", int'(q), 1);

`ifndef TFF_CNT_SAT_EN
    // Reset while the wrap pulse is high.
    load = 1'b1; d = 4'd9;
    tick();
    load = 1'b0;
    tick();
    check("wrap_before_reset", int'(wrap), 1);
    #2 reset = 1'b0;
    #1;
    mq = 0; mw = 0;
    check("wrap_cleared_by_reset", int'(wrap), 0);
    @(negedge clk);
    reset = 1'b1;
`endif

    for (int n = 0; n < 400; n++) begin
      load = ($urandom_range(0, 7) == 0);
      en   = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom_range(0, 3));
      d    = 4'($urandom);
      j    = 4'($urandom);
      k    = 4'($urandom);
      t    = 4'($urandom);
      tick();
      check("rand_q", int'(q), mq);
      check("rand_qbar", int'(qbar), (~mq) & 15);
      check("rand_tc", int'(tc), model_tc());
      check("rand_wrap", int'(wrap), mw);
      if ($urandom_range(0, 3) == 0) begin
        mode = 2'($urandom_range(0, 3));
        #1;
        check("rand_tc_modechg", int'(tc), model_tc());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
